// File: rtl/quad_input_filter_if.sv
// Encoder-side signal bundle for quad_input_filter: raw channels and clear in,
// debounced channels, step/error pulses and counters out.
interface quad_input_filter_if;
  logic               a_raw;
  logic               b_raw;
  logic               clear_counts;
  logic               a_clean;
  logic               b_clean;
  logic               step;
  logic               direction;
  logic signed [31:0] position;
  logic               quad_err;
  logic [15:0]        err_count;

  modport master (
    output a_raw, b_raw, clear_counts,
    input  a_clean, b_clean, step, direction, position, quad_err, err_count
  );

  modport slave (
    input  a_raw, b_raw, clear_counts,
    output a_clean, b_clean, step, direction, position, quad_err, err_count
  );
endinterface

// File: rtl/quad_input_filter.sv
// Quadrature encoder front end: per-channel synchronizer + stability filter,
// then an x4 decoder producing step/direction/position and error counting.

module quad_input_filter_chan #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic raw,
  output logic clean
);
  // Counter value at which the next stable sample completes FILTER_LEN samples.
  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 2);

  logic       sync1, sync2, sync_prev;
  logic [7:0] cnt;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      cnt       <= '0;
      clean     <= 1'b0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (sync2 == clean || sync2 != sync_prev) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        clean <= sync2;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

module quad_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic               clk_50,
  input  logic               reset_n,
  quad_input_filter_if.slave bus
);
  localparam int NUM_LANES = 2;

  // Lane 1 is channel A, lane 0 is channel B, so vectors read as {a,b}.
  logic [NUM_LANES-1:0] raw_vec, clean_vec, prev_pair, chg;
  logic                 one_chg, two_chg, rev;
  logic                 step_q, qerr_q, dir_q;
  logic signed [31:0]   pos_q;
  logic [15:0]          err_q;

  assign raw_vec = {bus.a_raw, bus.b_raw};

  quad_input_filter_chan #(.FILTER_LEN(FILTER_LEN)) u_chan [NUM_LANES-1:0] (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .raw     (raw_vec),
    .clean   (clean_vec)
  );

  assign chg     = clean_vec ^ prev_pair;
  assign one_chg = ^chg;
  assign two_chg = &chg;
  // For a single-bit change, A-now matching B-before means B leads A.
  assign rev     = ~(clean_vec[1] ^ prev_pair[0]);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      prev_pair <= '0;
      step_q    <= 1'b0;
      qerr_q    <= 1'b0;
      dir_q     <= 1'b0;
      pos_q     <= '0;
      err_q     <= '0;
    end else begin
      prev_pair <= clean_vec;
      step_q    <= one_chg;
      qerr_q    <= two_chg;
      if (one_chg) dir_q <= rev;
      if (bus.clear_counts) begin
        pos_q <= '0;
        err_q <= '0;
      end else begin
        if (one_chg) pos_q <= rev ? pos_q - 32'sd1 : pos_q + 32'sd1;
        if (two_chg && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      end
    end
  end

  assign bus.a_clean   = clean_vec[1];
  assign bus.b_clean   = clean_vec[0];
  assign bus.step      = step_q;
  assign bus.quad_err  = qerr_q;
  assign bus.direction = dir_q;
  assign bus.position  = pos_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_quad_input_filter.sv
// Bench for quad_input_filter: directed vector table, hand-written corner
// sequences, and random encoder traffic against a history-window model.
module tb_quad_input_filter;
  localparam int FL = 8;

  logic clk_50 = 1'b0;
  logic reset_n;
  always #10 clk_50 = ~clk_50;

  quad_input_filter_if bus();
  quad_input_filter #(.FILTER_LEN(FL)) dut (.clk_50(clk_50), .reset_n(reset_n), .bus(bus));

  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    logic a, b;
    int hold, steps, errs, lat;
    logic ac, bc;
    logic [31:0] pos;
    logic dir;
    logic [15:0] errc;
  } vec_t;
  vec_t tbl[$];

  // Reference model: raw history per channel, clean and decoder outputs.
  logic [FL+1:0] m_hist_a, m_hist_b;
  logic m_a, m_b, m_step, m_qerr, m_dir;
  logic [31:0] m_pos;
  logic [15:0] m_err;
  int m_prev_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int gidx(input logic a, input logic b);
    return a ? (b ? 2 : 1) : (b ? 3 : 0);
  endfunction

  // Clean takes a level once the last FL synchronized samples all agree on it.
  function automatic logic filt(input logic [FL+1:0] h, input logic cur);
    int ones = 0;
    for (int i = 2; i <= FL + 1; i++) ones += int'(h[i]);
    if (ones == FL) return 1'b1;
    if (ones == 0) return 1'b0;
    return cur;
  endfunction

  task automatic model_reset();
    m_hist_a = '0; m_hist_b = '0; m_a = 0; m_b = 0;
    m_step = 0; m_qerr = 0; m_dir = 0; m_pos = 0; m_err = 0; m_prev_idx = 0;
  endtask

  task automatic model_step();
    int d;
    d = (gidx(m_a, m_b) - m_prev_idx + 4) % 4;
    m_prev_idx = gidx(m_a, m_b);
    m_step = (d == 1 || d == 3);
    m_qerr = (d == 2);
    if (m_step) m_dir = (d == 3);
    if (bus.clear_counts) begin
      m_pos = 0; m_err = 0;
    end else begin
      if (d == 1) m_pos = m_pos + 1;
      if (d == 3) m_pos = m_pos - 1;
      if (d == 2 && m_err != 16'hFFFF) m_err = m_err + 1;
    end
    m_hist_a = {m_hist_a[FL:0], bus.a_raw};
    m_hist_b = {m_hist_b[FL:0], bus.b_raw};
    m_a = filt(m_hist_a, m_a);
    m_b = filt(m_hist_b, m_b);
  endtask

  task automatic check_all();
    chk("a_clean", bus.a_clean, m_a);
    chk("b_clean", bus.b_clean, m_b);
    chk("step", bus.step, m_step);
    chk("quad_err", bus.quad_err, m_qerr);
    chk("direction", bus.direction, m_dir);
    chk("position", bus.position, m_pos);
    chk("err_count", bus.err_count, m_err);
  endtask

  task automatic tick();
    @(posedge clk_50);
    if (reset_n) model_step();
    @(negedge clk_50);
    cyc++;
    check_all();
  endtask

  task automatic drive(input logic a, input logic b);
    bus.a_raw = a; bus.b_raw = b;
  endtask

  task automatic run_phase(input int n, output int steps, output int errs, output int lat);
    logic [1:0] start;
    start = {bus.a_clean, bus.b_clean};
    steps = 0; errs = 0; lat = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      steps += int'(bus.step);
      errs  += int'(bus.quad_err);
      if (lat == 0 && {bus.a_clean, bus.b_clean} != start) lat = i;
    end
  endtask

  task automatic pulse_clear();
    bus.clear_counts = 1'b1;
    tick();
    bus.clear_counts = 1'b0;
  endtask

  initial begin
    int st, er, lt, tot_st, tot_lt;
    logic a;
    //          a  b  hold st er lat ac bc pos              dir   errc
    tbl.push_back('{1, 0, 20, 1, 0, 10, 1, 0, 32'd1,          1'b0, 16'd0});
    tbl.push_back('{1, 1, 20, 1, 0, 10, 1, 1, 32'd2,          1'b0, 16'd0});
    tbl.push_back('{0, 1, 20, 1, 0, 10, 0, 1, 32'd3,          1'b0, 16'd0});
    tbl.push_back('{0, 0, 20, 1, 0, 10, 0, 0, 32'd4,          1'b0, 16'd0});
    tbl.push_back('{0, 1, 20, 1, 0, 10, 0, 1, 32'd3,          1'b1, 16'd0});
    tbl.push_back('{1, 1, 20, 1, 0, 10, 1, 1, 32'd2,          1'b1, 16'd0});
    tbl.push_back('{1, 0, 20, 1, 0, 10, 1, 0, 32'd1,          1'b1, 16'd0});
    tbl.push_back('{0, 0, 20, 1, 0, 10, 0, 0, 32'd0,          1'b1, 16'd0});
    tbl.push_back('{1, 1, 20, 0, 1, 10, 1, 1, 32'd0,          1'b1, 16'd1});
    tbl.push_back('{0, 0, 20, 0, 1, 10, 0, 0, 32'd0,          1'b1, 16'd2});
    tbl.push_back('{1, 0,  7, 0, 0,  0, 0, 0, 32'd0,          1'b1, 16'd2});
    tbl.push_back('{0, 0, 20, 0, 0,  0, 0, 0, 32'd0,          1'b1, 16'd2});

    // Reset with inputs high, then power-up 00->11 error
    model_reset();
    reset_n = 1'b0; bus.clear_counts = 1'b0; drive(1, 1);
    repeat (3) tick();
    chk("rst a_clean", bus.a_clean, 0);
    chk("rst step", bus.step, 0);
    chk("rst position", bus.position, 0);
    chk("rst err_count", bus.err_count, 0);
    reset_n = 1'b1;
    run_phase(12, st, er, lt);
    chk("pwrup latency", lt, FL + 2);
    chk("pwrup quad_err", er, 1);
    chk("pwrup step", st, 0);
    chk("pwrup err_count", bus.err_count, 1);
    drive(0, 0);
    run_phase(12, st, er, lt);
    chk("fall err_count", bus.err_count, 2);
    pulse_clear();
    chk("clear err_count", bus.err_count, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b);
      run_phase(tbl[i].hold, st, er, lt);
      chk($sformatf("tbl%0d steps", i), st, tbl[i].steps);
      chk($sformatf("tbl%0d errs", i), er, tbl[i].errs);
      chk($sformatf("tbl%0d latency", i), lt, tbl[i].lat);
      chk($sformatf("tbl%0d clean", i), {bus.a_clean, bus.b_clean}, {tbl[i].ac, tbl[i].bc});
      chk($sformatf("tbl%0d position", i), bus.position, tbl[i].pos);
      chk($sformatf("tbl%0d direction", i), bus.direction, tbl[i].dir);
      chk($sformatf("tbl%0d err_count", i), bus.err_count, tbl[i].errc);
    end

    // Bounce on A: 3-cycle pulses for 30 cycles, then a settled high
    a = 1'b0; tot_st = 0; tot_lt = 0;
    for (int i = 0; i < 10; i++) begin
      a = ~a; drive(a, 0);
      run_phase(3, st, er, lt);
      tot_st += st; tot_lt += lt;
    end
    drive(1, 0);
    run_phase(20, st, er, lt);
    chk("bounce early change", tot_lt + tot_st, 0);
    chk("bounce latency", lt, FL + 2);
    chk("bounce steps", st, 1);
    chk("bounce position", bus.position, 1);
    drive(0, 0);
    run_phase(15, st, er, lt);
    pulse_clear();

    // 40 reverse transitions
    tot_st = 0;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++) begin
        case (j)
          0: drive(0, 1);
          1: drive(1, 1);
          2: drive(1, 0);
          default: drive(0, 0);
        endcase
        run_phase(12, st, er, lt);
        tot_st += st;
      end
    chk("rev40 steps", tot_st, 40);
    chk("rev40 position", bus.position, 32'hFFFF_FFD8);
    chk("rev40 direction", bus.direction, 1);

    // Saturating error counter
    force dut.err_q = 16'hFFFF;
    #1 release dut.err_q;
    m_err = 16'hFFFF;
    drive(1, 1);
    run_phase(15, st, er, lt);
    chk("sat errs", er, 1);
    chk("sat err_count", bus.err_count, 16'hFFFF);
    chk("sat position", bus.position, 32'hFFFF_FFD8);
    drive(0, 0);
    run_phase(15, st, er, lt);
    chk("sat err_count 2", bus.err_count, 16'hFFFF);
    pulse_clear();

    // Position wrap both ways, then clear colliding with a step
    force dut.pos_q = 32'h7FFF_FFFF;
    #1 release dut.pos_q;
    m_pos = 32'h7FFF_FFFF;
    drive(1, 0);
    run_phase(15, st, er, lt);
    chk("wrap up", bus.position, 32'h8000_0000);
    drive(0, 0);
    run_phase(15, st, er, lt);
    chk("wrap down", bus.position, 32'h7FFF_FFFF);
    drive(1, 0);
    run_phase(15, st, er, lt);
    drive(1, 1);
    repeat (FL + 2) tick();
    bus.clear_counts = 1'b1;
    tick();
    bus.clear_counts = 1'b0;
    chk("clr+step step", bus.step, 1);
    chk("clr+step position", bus.position, 0);

    // Reset mid-filter
    drive(0, 1);
    run_phase(15, st, er, lt);
    drive(0, 0);
    run_phase(15, st, er, lt);
    drive(1, 0);
    repeat (FL) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async rst position", bus.position, 0);
    chk("async rst clean", {bus.a_clean, bus.b_clean}, 0);
    chk("async rst step", bus.step, 0);
    chk("async rst dir", bus.direction, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    run_phase(12, st, er, lt);
    chk("post-rst latency", lt, FL + 2);
    chk("post-rst steps", st, 1);
    chk("post-rst errs", er, 0);
    chk("post-rst position", bus.position, 1);

    // Random traffic against the model
    for (int seg = 0; seg < 250; seg++) begin
      int mode, hold;
      mode = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 14));
      if (mode < 4) bus.a_raw = ~bus.a_raw;
      else if (mode < 8) bus.b_raw = ~bus.b_raw;
      else if (mode == 8) drive(~bus.a_raw, ~bus.b_raw);
      if ($urandom_range(0, 59) == 0) begin
        reset_n = 1'b0;
        model_reset();
        tick();
        reset_n = 1'b1;
      end
      for (int c = 0; c < hold; c++) begin
        bus.clear_counts = ($urandom_range(0, 19) == 0);
        tick();
      end
      bus.clear_counts = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/quad_input_filter.md
QUAD_INPUT_FILTER -- requirements
Module: quad_input_filter

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive clk_50 cycles a synchronized input must hold a new level before the clean output takes it; legal range 2..255.
REQ-002 clk_50  input  1  system clock, 50 MHz; all state on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 a_raw  input  1  encoder channel A, asynchronous to clk_50, may bounce.
REQ-005 b_raw  input  1  encoder channel B, asynchronous to clk_50, may bounce.
REQ-006 clear_counts  input  1  synchronous, active-high clear of position and err_count.
REQ-007 a_clean  output  1  synchronized, debounced channel A; feeds the downstream encoder counter.
REQ-008 b_clean  output  1  synchronized, debounced channel B.
REQ-009 step  output  1  one-cycle pulse per legal quadrature transition.
REQ-010 direction  output  1  0 = clockwise (A leads B), 1 = counter-clockwise; valid with step, held until the next step.
REQ-011 position  output  32  signed x4 quadrature count.
REQ-012 quad_err  output  1  one-cycle pulse when A and B change in the same cycle.
REQ-013 err_count  output  16  unsigned count of quad_err pulses.

Function
REQ-014 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-015 Each channel SHALL have an 8-bit stability counter that resets to 0 whenever the synchronized value equals the clean value or changes from the previous cycle.
REQ-016 While the synchronized value differs from the clean value and is unchanged, the counter SHALL increment once per cycle; on reaching FILTER_LEN-1 the clean output SHALL take the synchronized value and the counter SHALL reset to 0.
REQ-017 Latency from a stable raw edge to the clean edge SHALL be exactly 2 + FILTER_LEN cycles; any pulse or bounce shorter than FILTER_LEN synchronized cycles SHALL produce no clean change.
REQ-018 The decoder SHALL register the previous clean pair {a,b}, and compare it with the current pair every cycle.
REQ-019 Forward sequence 00->10->11->01->00: step=1, direction=0, position+1, all registered one cycle after the clean change.
REQ-020 Reverse sequence 00->01->11->10->00: step=1, direction=1, position-1, with the same timing.
REQ-021 Both bits changing in one cycle SHALL give quad_err=1, step=0, and position and direction unchanged; err_count SHALL increment and saturate at 0xFFFF.
REQ-022 No clean change SHALL give step=0 and quad_err=0.
REQ-023 position SHALL wrap in two's complement (0x7FFFFFFF+1 -> 0x80000000, 0x80000000-1 -> 0x7FFFFFFF).
REQ-024 clear_counts=1 SHALL set position=0 and err_count=0 on the next edge, taking precedence over a same-cycle step or quad_err; the step and quad_err pulses themselves SHALL still assert.
REQ-025 clear_counts SHALL NOT affect the synchronizers, filters, clean outputs or direction.

Reset
REQ-026 reset_n=0 SHALL asynchronously force the synchronizer flops, stability counters, a_clean, b_clean, the previous-pair register, step, quad_err and direction to 0, and position and err_count to 0.
REQ-027 After reset release with inputs held high, the clean outputs SHALL rise after 2 + FILTER_LEN cycles as a simultaneous 00->11 change: one quad_err pulse and err_count=1.
REQ-028 Assertion of reset_n mid-filter or mid-transition SHALL discard all partial state, with no step or quad_err emitted on release.

Verification
REQ-029 FILTER_LEN=8; one forward cycle 00,10,11,01,00, each level held 20 cycles -> four step pulses, direction=0, position=4; each a_clean edge 10 cycles after its a_raw edge.
REQ-030 Bounce: a_raw toggled with 3-cycle pulses for 30 cycles, then held high -> a_clean rises once, 10 cycles after the final edge, with exactly one step.
REQ-031 Reverse: 40 reverse transitions from position=0 -> position=-40 (0xFFFFFFD8), direction=1.
REQ-032 Error path: a_raw and b_raw switched 00->11 on the same edge -> quad_err one cycle, err_count=1, position unchanged; preload err_count at 0xFFFF, repeat -> err_count stays 0xFFFF.
REQ-033 Wrap and clear: force position=0x7FFFFFFF, one forward step -> 0x80000000; clear_counts asserted in the same cycle as a step -> position=0 and step pulse still seen.
REQ-034 Reset: reset_n pulsed low mid-filter (counter at 5) -> all outputs 0 immediately, no step on release, and the full 2 + FILTER_LEN latency required again.
